// File: rtl/park_gate_ctrl.sv
// Parking entry/exit gate front-end: debounces the presence sensors, runs one barrier FSM
// per gate, and emits registered car_in / car_out pulses that never overlap.
module park_gate_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned OPEN_TIMEOUT    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic entry_sensor,
    input  logic entry_pass,
    input  logic exit_sensor,
    input  logic exit_pass,
    input  logic parking_full,
    output logic car_in,
    output logic car_out,
    output logic entry_barrier_open,
    output logic exit_barrier_open,
    output logic entry_denied
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned TW = $clog2(OPEN_TIMEOUT) + 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] T_LAST  = TW'(OPEN_TIMEOUT - 1);

    localparam logic [1:0] E_IDLE  = 2'd0;
    localparam logic [1:0] E_CHECK = 2'd1;
    localparam logic [1:0] E_OPEN  = 2'd2;
    localparam logic [1:0] E_DENY  = 2'd3;
    localparam logic [0:0] X_IDLE  = 1'b0;
    localparam logic [0:0] X_OPEN  = 1'b1;

    logic [CW-1:0] en_cnt, ex_cnt;
    logic          en_deb, ex_deb;
    logic          en_deb_q, ex_deb_q;
    logic          en_pass_q, ex_pass_q;
    logic [1:0]    e_state, e_state_nxt;
    logic [0:0]    x_state, x_state_nxt;
    logic [TW-1:0] e_timer, x_timer;
    logic          entry_req, exit_req;
    logic          out_pending;

    logic en_rise, ex_rise, entry_pass_rise, exit_pass_rise;
    assign en_rise         = en_deb & ~en_deb_q;
    assign ex_rise         = ex_deb & ~ex_deb_q;
    assign entry_pass_rise = entry_pass & ~en_pass_q;
    assign exit_pass_rise  = exit_pass & ~ex_pass_q;

    // Level changes only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_deb <= 1'b0;
            en_cnt <= '0;
        end else if (entry_sensor == en_deb) begin
            en_cnt <= '0;
        end else if (en_cnt == DB_LAST) begin
            en_deb <= entry_sensor;
            en_cnt <= '0;
        end else begin
            en_cnt <= en_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_deb <= 1'b0;
            ex_cnt <= '0;
        end else if (exit_sensor == ex_deb) begin
            ex_cnt <= '0;
        end else if (ex_cnt == DB_LAST) begin
            ex_deb <= exit_sensor;
            ex_cnt <= '0;
        end else begin
            ex_cnt <= ex_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_deb_q  <= 1'b0;
            ex_deb_q  <= 1'b0;
            en_pass_q <= 1'b0;
            ex_pass_q <= 1'b0;
        end else begin
            en_deb_q  <= en_deb;
            ex_deb_q  <= ex_deb;
            en_pass_q <= entry_pass;
            ex_pass_q <= exit_pass;
        end
    end

    always_comb begin
        e_state_nxt = e_state;
        entry_req   = 1'b0;
        case (e_state)
            E_IDLE:  if (en_rise) e_state_nxt = E_CHECK;
            E_CHECK: e_state_nxt = parking_full ? E_DENY : E_OPEN;
            E_OPEN: begin
                if (entry_pass_rise) begin
                    entry_req   = 1'b1;
                    e_state_nxt = E_IDLE;
                end else if (e_timer == T_LAST) begin
                    e_state_nxt = E_IDLE;
                end
            end
            E_DENY:  if (!en_deb) e_state_nxt = E_IDLE;
            default: e_state_nxt = E_IDLE;
        endcase
    end

    always_comb begin
        x_state_nxt = x_state;
        exit_req    = 1'b0;
        case (x_state)
            X_IDLE: if (ex_rise) x_state_nxt = X_OPEN;
            X_OPEN: begin
                if (exit_pass_rise) begin
                    exit_req    = 1'b1;
                    x_state_nxt = X_IDLE;
                end else if (x_timer == T_LAST) begin
                    x_state_nxt = X_IDLE;
                end
            end
            default: x_state_nxt = X_IDLE;
        endcase
    end

    // Timers run only while their barrier is open, so they are already zero on entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_state <= E_IDLE;
            x_state <= X_IDLE;
            e_timer <= '0;
            x_timer <= '0;
        end else begin
            e_state <= e_state_nxt;
            x_state <= x_state_nxt;
            e_timer <= (e_state == E_OPEN) ? e_timer + TW'(1) : '0;
            x_timer <= (x_state == X_OPEN) ? x_timer + TW'(1) : '0;
        end
    end

    // An exit event colliding with an entry event is deferred one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            car_in      <= 1'b0;
            car_out     <= 1'b0;
            out_pending <= 1'b0;
        end else begin
            car_in      <= entry_req;
            car_out     <= (exit_req | out_pending) & ~entry_req;
            out_pending <= (exit_req | out_pending) & entry_req;
        end
    end

    assign entry_barrier_open = (e_state == E_OPEN);
    assign entry_denied       = (e_state == E_DENY);
    assign exit_barrier_open  = (x_state == X_OPEN);

endmodule

// File: tb/tb_park_gate_ctrl.sv
// Scoreboard bench for park_gate_ctrl: a gate-level behavioural model queues the expected
// outputs for every clock edge; a separate monitor compares them after each edge.
module tb_park_gate_ctrl;

    localparam int DB = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic entry_sensor = 1'b0, entry_pass = 1'b0, exit_sensor = 1'b0, exit_pass = 1'b0;
    logic parking_full = 1'b0;
    logic car_in, car_out, entry_barrier_open, exit_barrier_open, entry_denied;

    park_gate_ctrl #(.DEBOUNCE_CYCLES(DB), .OPEN_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .entry_sensor(entry_sensor), .entry_pass(entry_pass),
        .exit_sensor(exit_sensor), .exit_pass(exit_pass),
        .parking_full(parking_full),
        .car_in(car_in), .car_out(car_out),
        .entry_barrier_open(entry_barrier_open), .exit_barrier_open(exit_barrier_open),
        .entry_denied(entry_denied)
    );

    always #5 clk = ~clk;

    typedef enum {G_IDLE, G_CHECK, G_OPEN, G_DENY} gate_t;
    gate_t        m_ent = G_IDLE, m_ext = G_IDLE;
    int           m_ent_deadline = 0, m_ext_deadline = 0;
    logic [DB-1:0] m_en_hist = '0, m_ex_hist = '0;
    logic         m_en_deb = 1'b0, m_ex_deb = 1'b0, m_en_rose = 1'b0, m_ex_rose = 1'b0;
    logic         m_en_pp = 1'b0, m_ex_pp = 1'b0;
    int           m_out_due[$];
    int           m_cyc = 0;

    logic [4:0] exp_q[$];
    int         exp_cyc[$];
    int         tests = 0;
    int         fails = 0;

    // Debounced level follows raw once the last DB samples all disagree with it.
    function automatic void deb_step(input logic raw, inout logic [DB-1:0] hist,
                                     inout logic deb, output logic rose);
        hist = {hist[DB-2:0], raw};
        rose = 1'b0;
        if (hist == {DB{~deb}}) begin
            deb  = ~deb;
            rose = deb;
        end
    endfunction

    task automatic model_edge(input logic r, es, ep, xs, xp, full);
        logic cin, cout;
        cin  = 1'b0;
        cout = 1'b0;
        if (r) begin
            m_ent = G_IDLE;  m_ext = G_IDLE;
            m_en_hist = '0;  m_ex_hist = '0;
            m_en_deb = 1'b0; m_ex_deb = 1'b0;
            m_en_rose = 1'b0; m_ex_rose = 1'b0;
            m_en_pp = 1'b0;  m_ex_pp = 1'b0;
            m_out_due.delete();
        end else begin
            case (m_ent)
                G_IDLE:  if (m_en_rose) m_ent = G_CHECK;
                G_CHECK: if (full) m_ent = G_DENY;
                         else begin m_ent = G_OPEN; m_ent_deadline = m_cyc + TO; end
                G_OPEN:  if (ep && !m_en_pp) begin cin = 1'b1; m_ent = G_IDLE; end
                         else if (m_cyc >= m_ent_deadline) m_ent = G_IDLE;
                G_DENY:  if (!m_en_deb) m_ent = G_IDLE;
                default: m_ent = G_IDLE;
            endcase
            case (m_ext)
                G_IDLE:  if (m_ex_rose) begin m_ext = G_OPEN; m_ext_deadline = m_cyc + TO; end
                G_OPEN:  if (xp && !m_ex_pp) begin m_out_due.push_back(m_cyc); m_ext = G_IDLE; end
                         else if (m_cyc >= m_ext_deadline) m_ext = G_IDLE;
                default: m_ext = G_IDLE;
            endcase
            deb_step(es, m_en_hist, m_en_deb, m_en_rose);
            deb_step(xs, m_ex_hist, m_ex_deb, m_ex_rose);
            m_en_pp = ep;
            m_ex_pp = xp;
            if (m_out_due.size() > 0 && !cin) begin
                cout = 1'b1;
                void'(m_out_due.pop_front());
            end
        end
        exp_q.push_back({m_ent == G_OPEN, m_ext == G_OPEN, m_ent == G_DENY, cin, cout});
        exp_cyc.push_back(m_cyc);
        m_cyc++;
    endtask

    // One clock of stimulus: applied mid-cycle, sampled at the next rising edge.
    task automatic cyc(input logic r, es, ep, xs, xp, full);
        @(negedge clk);
        rst = r; entry_sensor = es; entry_pass = ep;
        exit_sensor = xs; exit_pass = xp; parking_full = full;
        model_edge(r, es, ep, xs, xp, full);
    endtask

    initial begin : monitor
        logic [4:0] exp_v, act;
        int c;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                c     = exp_cyc.pop_front();
                act   = {entry_barrier_open, exit_barrier_open, entry_denied, car_in, car_out};
                tests++;
                if (act !== exp_v) begin
                    fails++;
                    $display("FAIL outputs edge %0d: got %b required %b (entry_open,exit_open,denied,car_in,car_out)",
                             c, act, exp_v);
                end
            end
        end
    end

    initial begin : stimulus
        logic es, ep, xs, xp, full, r;
        // reset with toggling inputs, then idle
        cyc(1, 1, 1, 1, 1, 1);
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0);
        // normal entry with pass three cycles after opening
        for (int i = 0; i < 12; i++) cyc(0, 1, i == 8, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0);
        // bounce never settles
        for (int i = 0; i < 8; i++) cyc(0, (i % 2) == 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0);
        // full lot, then full drops while car present, then car leaves
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) cyc(0, 1, i == 3, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0);
        // exit timeout, then late pass
        for (int i = 0; i < 26; i++) cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, i == 1, 1, i == 1, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0);
        // collision: both pass edges on the same clock
        for (int i = 0; i < 14; i++) cyc(0, 1, i == 9, 1, i == 9, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0);
        // reset while both barriers open
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 1, 0, 0);
        cyc(1, 1, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0);
        // reset right after a collision, with the exit pulse still pending
        for (int i = 0; i < 10; i++) cyc(0, 1, i == 9, 1, i == 9, 0);
        cyc(1, 1, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0);
        // resumes: exit then entry
        for (int i = 0; i < 12; i++) cyc(0, 1, i == 10, 1, i == 7, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0);
        // randomized traffic
        es = 0; xs = 0; full = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0)  es = ~es;
            if ($urandom_range(0, 5) == 0)  xs = ~xs;
            if ($urandom_range(0, 24) == 0) full = ~full;
            ep = ($urandom_range(0, 3) == 0);
            xp = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 399) == 0);
            cyc(r, es, ep, xs, xp, full);
        end
        cyc(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
